// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use bubbles, taken-branch squash, data-memory
// wait freeze and the HLT drain sequence, plus a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_SrcReg1,
    input  logic [3:0]       id_SrcReg2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_halt,
    input  logic             ex_Data_Mem_en,
    input  logic             ex_Data_Mem_wr,
    input  logic             ex_WriteReg,
    input  logic [3:0]       ex_DstReg,
    input  logic             ex_flush,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [DW-1:0]    r_drain_cnt;
    logic [DW-1:0]    w_next_drain;
    logic             r_halted;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_ex_valid;
    logic w_src1_hit;
    logic w_src2_hit;
    logic w_load_use;
    logic w_branch;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_ifid_flush;
    logic w_idex_en;
    logic w_idex_flush;
    logic w_exmem_en;

    assign w_ex_valid = !ex_flush;
    assign w_src1_hit = id_use1 && (id_SrcReg1 == ex_DstReg);
    assign w_src2_hit = id_use2 && (id_SrcReg2 == ex_DstReg);
    // A load in EX whose destination feeds the ID instruction; R0 is compared like any other.
    assign w_load_use = w_ex_valid && ex_Data_Mem_en && !ex_Data_Mem_wr && ex_WriteReg
                        && (w_src1_hit || w_src2_hit);
    assign w_branch   = w_ex_valid && ex_branch_taken;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_en    = 1'b0;
        w_idex_flush = 1'b0;
        w_exmem_en   = 1'b0;
        w_next_state = r_state;
        w_next_drain = r_drain_cnt;

        if (rst) begin
            case (r_state)
                ST_RUN: begin
                    if (mem_busy) begin
                        // Whole pipeline freezes; defaults already hold everything.
                    end else if (w_branch) begin
                        w_pc_en      = 1'b1;
                        w_ifid_en    = 1'b1;
                        w_ifid_flush = 1'b1;
                        w_idex_en    = 1'b1;
                        w_idex_flush = 1'b1;
                        w_exmem_en   = 1'b1;
                    end else if (w_load_use) begin
                        w_idex_en    = 1'b1;
                        w_idex_flush = 1'b1;
                        w_exmem_en   = 1'b1;
                    end else if (id_halt) begin
                        w_idex_en    = 1'b1;
                        w_exmem_en   = 1'b1;
                        w_next_state = ST_DRAIN;
                        w_next_drain = DRAIN_LOAD;
                    end else begin
                        w_pc_en    = 1'b1;
                        w_ifid_en  = 1'b1;
                        w_idex_en  = 1'b1;
                        w_exmem_en = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Only bubbles or the HLT occupy EX here, so a branch cannot be taken.
                    w_idex_flush = 1'b1;
                    if (!mem_busy) begin
                        w_idex_en  = 1'b1;
                        w_exmem_en = 1'b1;
                        if (r_drain_cnt == '0) begin
                            w_next_state = ST_HALTED;
                        end else begin
                            w_next_drain = r_drain_cnt - DW'(1);
                        end
                    end
                end
                ST_HALTED: begin
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_drain = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_drain;
            r_halted    <= (w_next_state == ST_HALTED);
            if ((r_state != ST_HALTED) && !w_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_en      = w_pc_en;
    assign ifid_en    = w_ifid_en;
    assign ifid_flush = w_ifid_flush;
    assign idex_en    = w_idex_en;
    assign idex_flush = w_idex_flush;
    assign exmem_en   = w_exmem_en;
    assign halted     = r_halted;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written drain/freeze
// sequences and randomized traffic against a behavioural model of the stall rules.
module tb_hazard_ctrl;

    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 16;
    localparam int SAT_W        = 4;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic ifidf;
        logic idex;
        logic idexf;
        logic exmem;
    } ctrl_t;

    localparam ctrl_t C_NORM  = 6'b110101;
    localparam ctrl_t C_BUBL  = 6'b000111;
    localparam ctrl_t C_SQSH  = 6'b111111;
    localparam ctrl_t C_HALT  = 6'b000101;
    localparam ctrl_t C_FRZ   = 6'b000000;
    localparam ctrl_t C_DRBSY = 6'b000010;

    typedef struct {
        logic [3:0] src1;
        logic [3:0] src2;
        logic       use1;
        logic       use2;
        logic       halt;
        logic       men;
        logic       mwr;
        logic       wr;
        logic [3:0] dst;
        logic       flush;
        logic       br;
        logic       busy;
        ctrl_t      exp;
    } vec_t;

    typedef enum int {M_RUN, M_DRAIN, M_HALTED} mode_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [3:0]       id_SrcReg1, id_SrcReg2, ex_DstReg;
    logic             id_use1, id_use2, id_halt;
    logic             ex_Data_Mem_en, ex_Data_Mem_wr, ex_WriteReg, ex_flush, ex_branch_taken, mem_busy;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, halted;
    logic [CNT_W-1:0] stall_cnt;
    logic             s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_halted;
    logic [SAT_W-1:0] s_stall_cnt;

    ctrl_t dut_ctrl, sat_ctrl;
    assign dut_ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en};
    assign sat_ctrl = {s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en};

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst),
        .id_SrcReg1(id_SrcReg1), .id_SrcReg2(id_SrcReg2),
        .id_use1(id_use1), .id_use2(id_use2), .id_halt(id_halt),
        .ex_Data_Mem_en(ex_Data_Mem_en), .ex_Data_Mem_wr(ex_Data_Mem_wr),
        .ex_WriteReg(ex_WriteReg), .ex_DstReg(ex_DstReg), .ex_flush(ex_flush),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(SAT_W)) u_sat (
        .clk(clk), .rst(rst),
        .id_SrcReg1(id_SrcReg1), .id_SrcReg2(id_SrcReg2),
        .id_use1(id_use1), .id_use2(id_use2), .id_halt(id_halt),
        .ex_Data_Mem_en(ex_Data_Mem_en), .ex_Data_Mem_wr(ex_Data_Mem_wr),
        .ex_WriteReg(ex_WriteReg), .ex_DstReg(ex_DstReg), .ex_flush(ex_flush),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
        .idex_en(s_idex_en), .idex_flush(s_idex_flush), .exmem_en(s_exmem_en),
        .halted(s_halted), .stall_cnt(s_stall_cnt)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    mode_t m_mode   = M_RUN;
    int    m_owed   = 0;
    int    m_stalls = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: the pipeline is running, draining a fixed number of bubbles, or parked.
    function automatic bit model_load_use();
        return !ex_flush && ex_Data_Mem_en && !ex_Data_Mem_wr && ex_WriteReg &&
               ((id_use1 && id_SrcReg1 == ex_DstReg) || (id_use2 && id_SrcReg2 == ex_DstReg));
    endfunction

    function automatic ctrl_t model_ctrl();
        if (!rst) return C_FRZ;
        case (m_mode)
            M_RUN: begin
                if (mem_busy)                      return C_FRZ;
                if (!ex_flush && ex_branch_taken)  return C_SQSH;
                if (model_load_use())              return C_BUBL;
                if (id_halt)                       return C_HALT;
                return C_NORM;
            end
            M_DRAIN: return mem_busy ? C_DRBSY : C_BUBL;
            default: return C_FRZ;
        endcase
    endfunction

    task automatic model_reset();
        m_mode   = M_RUN;
        m_owed   = 0;
        m_stalls = 0;
    endtask

    task automatic model_step();
        ctrl_t c;
        c = model_ctrl();
        if (m_mode != M_HALTED && !c.pc) m_stalls++;
        if (m_mode == M_RUN && c == C_HALT) begin
            m_mode = M_DRAIN;
            m_owed = DRAIN_CYCLES;
        end else if (m_mode == M_DRAIN && !mem_busy) begin
            m_owed--;
            if (m_owed == 0) m_mode = M_HALTED;
        end
    endtask

    task automatic sample(input string tag);
        @(negedge clk);
        check({tag, ".ctrl"},     dut_ctrl,    model_ctrl());
        check({tag, ".sat_ctrl"}, sat_ctrl,    model_ctrl());
        check({tag, ".halted"},   halted,      (m_mode == M_HALTED));
        check({tag, ".s_halted"}, s_halted,    (m_mode == M_HALTED));
        check({tag, ".cnt"},      stall_cnt,   (m_stalls > 65535) ? 65535 : m_stalls);
        check({tag, ".cnt4"},     s_stall_cnt, (m_stalls > 15) ? 15 : m_stalls);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic cycle(input string tag);
        sample(tag);
        advance();
    endtask

    task automatic zero_inputs();
        id_SrcReg1 = '0; id_SrcReg2 = '0; id_use1 = 0; id_use2 = 0; id_halt = 0;
        ex_Data_Mem_en = 0; ex_Data_Mem_wr = 0; ex_WriteReg = 0; ex_DstReg = '0;
        ex_flush = 0; ex_branch_taken = 0; mem_busy = 0;
    endtask

    task automatic load_use_inputs();
        zero_inputs();
        ex_Data_Mem_en = 1; ex_WriteReg = 1; ex_DstReg = 4'h5; id_use2 = 1; id_SrcReg2 = 4'h5;
    endtask

    task automatic do_reset();
        rst = 0;
        model_reset();
        cycle("rst");
        rst = 1;
    endtask

    // HLT drain with an optional mem_busy pulse; returns edges until halted is seen.
    task automatic run_hlt(input string tag, input int busy_at, input int busy_len, input int exp_edges);
        int found = -1;
        do_reset();
        for (int e = 0; e < 16 && found < 0; e++) begin
            zero_inputs();
            id_halt  = (e == 0);
            mem_busy = (e >= busy_at) && (e < busy_at + busy_len);
            sample(tag);
            if (e == 0) check({tag, ".c0"}, dut_ctrl, C_HALT);
            if (halted) found = e;
            advance();
        end
        check({tag, ".edges"}, found, exp_edges);
        zero_inputs();
        id_halt = 1; ex_branch_taken = 1;
        repeat (3) cycle({tag, ".parked"});
    endtask

    vec_t tbl[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, C_NORM};
        tbl[1]  = '{4'h0, 4'h5, 0, 1, 0, 1, 0, 1, 4'h5, 0, 0, 0, C_BUBL};
        tbl[2]  = '{4'h0, 4'h5, 0, 1, 0, 1, 1, 1, 4'h5, 0, 0, 0, C_NORM};
        tbl[3]  = '{4'h0, 4'h5, 0, 1, 0, 1, 0, 1, 4'h5, 1, 0, 0, C_NORM};
        tbl[4]  = '{4'h9, 4'h0, 1, 0, 0, 1, 0, 1, 4'h9, 0, 0, 0, C_BUBL};
        tbl[5]  = '{4'h9, 4'h0, 0, 0, 0, 1, 0, 1, 4'h9, 0, 0, 0, C_NORM};
        tbl[6]  = '{4'h0, 4'h0, 1, 1, 0, 1, 0, 1, 4'h0, 0, 0, 0, C_BUBL};
        tbl[7]  = '{4'h5, 4'h5, 1, 1, 0, 1, 0, 0, 4'h5, 0, 0, 0, C_NORM};
        tbl[8]  = '{4'h5, 4'h5, 1, 1, 0, 0, 0, 1, 4'h5, 0, 0, 0, C_NORM};
        tbl[9]  = '{4'h0, 4'h5, 0, 1, 1, 1, 0, 1, 4'h5, 0, 1, 0, C_SQSH};
        tbl[10] = '{4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 1, 0, C_NORM};
        tbl[11] = '{4'h0, 4'h5, 0, 1, 0, 1, 0, 1, 4'h5, 0, 0, 1, C_FRZ};
        tbl[12] = '{4'h0, 4'h0, 0, 0, 1, 0, 0, 0, 4'h0, 0, 0, 1, C_FRZ};
        tbl[13] = '{4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1, C_FRZ};
        tbl[14] = '{4'h7, 4'h3, 1, 1, 0, 1, 0, 1, 4'h4, 0, 0, 0, C_NORM};

        rst = 0;
        zero_inputs();
        model_reset();
        cycle("por");
        cycle("por2");
        rst = 1;

        foreach (tbl[i]) begin
            id_SrcReg1 = tbl[i].src1;  id_SrcReg2 = tbl[i].src2;
            id_use1 = tbl[i].use1;     id_use2 = tbl[i].use2;     id_halt = tbl[i].halt;
            ex_Data_Mem_en = tbl[i].men; ex_Data_Mem_wr = tbl[i].mwr; ex_WriteReg = tbl[i].wr;
            ex_DstReg = tbl[i].dst;    ex_flush = tbl[i].flush;
            ex_branch_taken = tbl[i].br; mem_busy = tbl[i].busy;
            sample($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.vec", i), dut_ctrl, tbl[i].exp);
            if (i == 0) check("release.cnt", stall_cnt, 0);
            if (i == 2) check("lu.cnt", stall_cnt, 1);
            advance();
        end

        // mem_busy freezes a pending load-use for 4 cycles, then the bubble goes in.
        do_reset();
        load_use_inputs();
        mem_busy = 1;
        repeat (4) cycle("busy");
        mem_busy = 0;
        sample("busy_drop");
        check("busy_drop.cnt", stall_cnt, 4);
        check("busy_drop.vec", dut_ctrl, C_BUBL);
        advance();

        run_hlt("hlt", 0, 0, 4);
        run_hlt("hlt_busy", 2, 2, 6);

        // Asynchronous reset in the middle of DRAIN.
        do_reset();
        zero_inputs();
        id_halt = 1;
        cycle("mid.hlt");
        id_halt = 0;
        cycle("mid.drain");
        rst = 0;
        model_reset();
        cycle("mid.rst");
        rst = 1;
        sample("mid.rel");
        check("mid.rel.vec", dut_ctrl, C_NORM);
        check("mid.rel.cnt", stall_cnt, 0);
        check("mid.rel.halted", halted, 0);
        advance();

        // Saturation of the narrow counter.
        do_reset();
        load_use_inputs();
        repeat (20) cycle("sat");
        sample("sat_end");
        check("sat.cnt4", s_stall_cnt, 15);
        check("sat.cnt16", stall_cnt, 20);
        advance();

        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            for (int k = 0; k < 60; k++) begin
                id_SrcReg1      = 4'($urandom_range(0, 3));
                id_SrcReg2      = 4'($urandom_range(0, 3));
                ex_DstReg       = 4'($urandom_range(0, 3));
                id_use1         = 1'($urandom_range(0, 1));
                id_use2         = 1'($urandom_range(0, 1));
                id_halt         = ($urandom_range(0, 19) == 0);
                ex_Data_Mem_en  = 1'($urandom_range(0, 1));
                ex_Data_Mem_wr  = ($urandom_range(0, 3) == 0);
                ex_WriteReg     = ($urandom_range(0, 3) != 0);
                ex_flush        = ($urandom_range(0, 3) == 0);
                ex_branch_taken = ($urandom_range(0, 7) == 0);
                mem_busy        = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 49) == 0) begin
                    rst = 0;
                    model_reset();
                    cycle($sformatf("rnd%0d.rst", blk));
                    rst = 1;
                end else begin
                    cycle($sformatf("rnd%0d", blk));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller.
- Drives the enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Consumes the registered ID/EX control outputs (EX-stage view) and the ID-stage source-register fields.
- Resolves load-use stalls, taken-branch squashes, data-memory wait stalls and the HLT drain sequence.
- Keeps a saturating stall-cycle counter for performance checks.

Parameters:
- DRAIN_CYCLES, 3, number of bubble cycles after HLT enters EX before halted asserts (EX, MEM, WB).
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- id_SrcReg1  input  4  ID-stage source register 1.
- id_SrcReg2  input  4  ID-stage source register 2.
- id_use1  input  1  ID instruction reads id_SrcReg1.
- id_use2  input  1  ID instruction reads id_SrcReg2.
- id_halt  input  1  ID instruction is HLT.
- ex_Data_Mem_en  input  1  EX instruction accesses data memory.
- ex_Data_Mem_wr  input  1  EX instruction is a store.
- ex_WriteReg  input  1  EX instruction writes the register file.
- ex_DstReg  input  4  EX destination register.
- ex_flush  input  1  EX slot holds a bubble.
- ex_branch_taken  input  1  branch resolved taken in EX.
- mem_busy  input  1  data memory is not ready this cycle.
- pc_en  output  1  PC write enable.
- ifid_en  output  1  IF/ID write enable.
- ifid_flush  output  1  squash the instruction entering IF/ID.
- idex_en  output  1  ID/EX write enable.
- idex_flush  output  1  insert a bubble into ID/EX.
- exmem_en  output  1  EX/MEM write enable.
- halted  output  1  pipeline drained after HLT; registered.
- stall_cnt  output  CNT_W  cycles with pc_en=0 while not HALTED; saturating.

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN, with drain counter 0, stall_cnt 0 and halted 0.
- While rst=0: pc_en, ifid_en, idex_en and exmem_en are 0; ifid_flush and idex_flush are 0.
- Control outputs are combinational from state and inputs, giving zero-cycle response. Only state, halted, stall_cnt and the drain counter are registered.
- ex_valid = !ex_flush.
- load_use = ex_valid & ex_Data_Mem_en & !ex_Data_Mem_wr & ex_WriteReg & ((id_use1 & id_SrcReg1==ex_DstReg) | (id_use2 & id_SrcReg2==ex_DstReg)). All four bits are compared; R0 gets no exemption.
- Priority in RUN (highest first):
  1. mem_busy: every enable is 0 and both flushes are 0. The whole pipeline freezes; no state change.
  2. ex_valid & ex_branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_flush=1, exmem_en=1. A coincident id_halt or load_use is squashed.
  3. load_use: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1. One bubble per cycle; the stall repeats while the condition holds.
  4. id_halt: pc_en=0, ifid_en=0, idex_en=1, idex_flush=0 (HLT passes into EX), exmem_en=1. Next state is DRAIN, with the counter loaded to DRAIN_CYCLES-1.
  5. Otherwise all enables are 1 and the flushes are 0.
- DRAIN:
  - pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=(!mem_busy).
  - If mem_busy: idex_en=0 and the counter holds.
  - Else: the counter decrements. When it is 0 and mem_busy=0, next state is HALTED.
  - ex_branch_taken is ignored in DRAIN, because only bubbles or the HLT occupy EX.
- HALTED: all enables are 0, flushes are 0 and halted=1. Only reset exits this state.
- stall_cnt:
  - Increments by 1 on each edge where the state is not HALTED, pc_en=0 and rst=1.
  - Holds at 2^CNT_W-1.
  - mem_busy cycles and DRAIN cycles count.
- Asynchronous reset mid-DRAIN or in HALTED returns the FSM immediately to RUN with counters cleared.

Test Plan:
- Reset release, all inputs 0 -> pc_en=ifid_en=idex_en=exmem_en=1, flushes 0, halted=0, stall_cnt=0.
- Load-use:
  - Stimulus: ex_Data_Mem_en=1, ex_Data_Mem_wr=0, ex_WriteReg=1, ex_DstReg=4'h5, ex_flush=0, id_use2=1, id_SrcReg2=4'h5.
  - Response: pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle, stall_cnt=1.
  - Same stimulus with ex_Data_Mem_wr=1 or ex_flush=1 -> no stall.
- Branch taken with coincident load_use and id_halt -> ifid_flush=1, idex_flush=1, pc_en=1; state stays RUN; stall_cnt unchanged.
- mem_busy held 4 cycles while load_use=1 -> all enables 0, flushes 0 for 4 cycles; stall_cnt=4. Load-use bubble follows on the first cycle after mem_busy drops.
- HLT with DRAIN_CYCLES=3:
  - id_halt=1 -> cycle 0 idex_flush=0, pc_en=0.
  - Three DRAIN cycles with idex_flush=1.
  - halted=1 after the 4th edge.
  - A mem_busy pulse of 2 cycles inside DRAIN delays halted by exactly 2 cycles.
- Reset mid-DRAIN (rst=0 for 1 cycle), then release -> enables 1, halted=0, stall_cnt=0. Saturation check with CNT_W=4: 20 stall cycles -> stall_cnt=15.
